// File: rtl/axis_tlast_framer_if.sv
// axis_tlast_framer_if: AXI4-Stream beat bundle used for the framer's input and output ports.
interface axis_tlast_framer_if #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, output tready);
endinterface

// File: rtl/axis_tlast_framer.sv
// axis_tlast_framer: inserts TLAST by data match, beat count or force pulse, with registered output.
// AXIS_TLAST_FRAMER_SKID_EN selects a skid-buffered output with registered s_tready.
module axis_tlast_framer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_WIDTH-1:0] cfg_cmp_value,
  input  logic [DATA_WIDTH-1:0] cfg_cmp_mask,
  input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
  input  logic                  force_last,
  axis_tlast_framer_if.slave    s,
  axis_tlast_framer_if.master   m,
  output logic [31:0]           frame_count,
  output logic                  frame_active
);
  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] val_q, val_d, mask_q, mask_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, beat_cnt_q, beat_cnt_d, eff_len;
  logic                  force_q, force_d, active_q, active_d;
  logic [31:0]           fc_q, fc_d;
  logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  accept, first, in_last, is_match, cnt_hit;

  // The first beat of a frame is judged against the live cfg it is about to latch.
  always_comb begin
    accept     = s.tvalid && s.tready;
    first      = !active_q;
    mode_d     = (accept && first) ? cfg_mode : mode_q;
    val_d      = (accept && first) ? cfg_cmp_value : val_q;
    mask_d     = (accept && first) ? cfg_cmp_mask : mask_q;
    len_d      = (accept && first) ? cfg_frame_len : len_q;
    eff_len    = (len_d == '0) ? ONE : len_d;
    is_match   = (s.tdata & mask_d) == val_d;
    cnt_hit    = beat_cnt_q == eff_len - ONE;
    in_last    = force_q || force_last || (mode_d[0] && is_match) || (mode_d[1] && cnt_hit);
    beat_cnt_d = accept ? (in_last ? '0 : beat_cnt_q + ONE) : beat_cnt_q;
    force_d    = (accept && in_last) ? 1'b0 : (force_q || force_last);
    active_d   = accept ? !in_last : active_q;
    fc_d       = (m.tvalid && m.tready && m.tlast) ? fc_q + 32'd1 : fc_q;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      mode_q      <= '0;
      val_q       <= '0;
      mask_q      <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      force_q     <= 1'b0;
      active_q    <= 1'b0;
      fc_q        <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      mode_q      <= mode_d;
      val_q       <= val_d;
      mask_q      <= mask_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      force_q     <= force_d;
      active_q    <= active_d;
      fc_q        <= fc_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef AXIS_TLAST_FRAMER_SKID_EN
  logic                  skid_valid_q, skid_valid_d, skid_last_q, skid_last_d, s_rdy_q, s_rdy_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  out_ready, to_skid;

  // A beat accepted while the output stalls parks in the skid entry; ready drops until it drains.
  always_comb begin
    out_ready    = m.tready || !out_valid_q;
    to_skid      = accept && !out_ready;
    out_valid_d  = out_ready ? (skid_valid_q || accept) : out_valid_q;
    out_data_d   = (skid_valid_q && out_ready) ? skid_data_q : (accept && out_ready) ? s.tdata : out_data_q;
    out_last_d   = (skid_valid_q && out_ready) ? skid_last_q : (accept && out_ready) ? in_last : out_last_q;
    skid_valid_d = to_skid || (skid_valid_q && !out_ready);
    skid_data_d  = to_skid ? s.tdata : skid_data_q;
    skid_last_d  = to_skid ? in_last : skid_last_q;
    s_rdy_d      = !skid_valid_d;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_data_q  <= '0;
      s_rdy_q      <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_last_q  <= skid_last_d;
      skid_data_q  <= skid_data_d;
      s_rdy_q      <= s_rdy_d;
    end
  end

  assign s.tready = s_rdy_q;
`else
  logic rdy_q;

  always_comb begin
    out_valid_d = s.tready ? accept : out_valid_q;
    out_data_d  = accept ? s.tdata : out_data_q;
    out_last_d  = accept ? in_last : out_last_q;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) rdy_q <= 1'b0;
    else          rdy_q <= 1'b1;
  end

  assign s.tready = rdy_q && (m.tready || !out_valid_q);
`endif

  assign m.tvalid     = out_valid_q;
  assign m.tdata      = out_data_q;
  assign m.tlast      = out_last_q;
  assign frame_count  = fc_q;
  assign frame_active = active_q;
endmodule
